// File: rtl/lane_permute_engine_pkg.sv
// Shared constants, FSM state type and the 5x5 cell permutation used by the
// lane permute engine and anything that needs to model it.
package lane_permute_engine_pkg;

  localparam int DIM     = 5;
  localparam int N_CELLS = DIM * DIM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pe_state_e;

  // Destination cell of cell i under one forward round; cell 12 maps to itself.
  function automatic int pi_dst(input int i);
    int x, y, xp, yp, nx, ny;
    x  = i % DIM;
    y  = i / DIM;
    xp = (x + 3) % DIM;
    yp = (y + 3) % DIM;
    nx = (yp + 2) % DIM;
    ny = (((2 * xp + 3 * yp) % DIM) + 2) % DIM;
    return DIM * ny + nx;
  endfunction

endpackage

// File: rtl/lane_permute_engine_counter.sv
// Loadable down-counter used as the per-transaction round counter.
module lane_permute_engine_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             dn_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)                    cnt_d = ld_val_i;
    else if (dn_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lane_permute_engine_pi_map.sv
// One round of the cell permutation, forward or inverse; pure wiring plus a
// 2:1 select, so it adds only a mux level to the round path.
module lane_pi_map
  import lane_permute_engine_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [N_CELLS*W-1:0] cur,
  input  logic                 inverse,
  output logic [N_CELLS*W-1:0] next
);

  logic [N_CELLS-1:0][W-1:0] cur_c;
  logic [N_CELLS-1:0][W-1:0] fwd;
  logic [N_CELLS-1:0][W-1:0] inv;

  assign cur_c = cur;

  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    localparam int D = pi_dst(i);
    assign fwd[D] = cur_c[i];
    assign inv[i] = cur_c[D];
  end

  assign next = inverse ? inv : fwd;

endmodule

// File: rtl/lane_permute_engine.sv
// Multi-round 5x5 lane permutation engine: accept a state, apply R rounds of
// the forward/inverse map one per clock, then hold the result until taken.
module lane_permute_engine
  import lane_permute_engine_pkg::*;
#(
  parameter  int W          = 1,
  parameter  int MAX_ROUNDS = 24,
  localparam int RW         = $clog2(MAX_ROUNDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CELLS*W-1:0] in_data,
  input  logic [RW-1:0]        in_rounds,
  input  logic                 in_inverse,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_CELLS*W-1:0] out_data,
  output logic                 busy
);

  pe_state_e             st_q;
  logic [N_CELLS*W-1:0]  data_q;
  logic                  inv_q;
  logic [N_CELLS*W-1:0]  mapped;
  logic [RW-1:0]         rounds_clamped;
  logic [RW-1:0]         cnt;
  logic                  accept;

  assign rounds_clamped = (in_rounds > RW'(MAX_ROUNDS)) ? RW'(MAX_ROUNDS) : in_rounds;
  assign accept         = (st_q == IDLE) && in_valid;

  lane_pi_map #(.W(W)) u_map (
    .cur     (data_q),
    .inverse (inv_q),
    .next    (mapped)
  );

  lane_permute_engine_counter #(.WIDTH(RW)) u_rounds (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (accept),
    .ld_val_i (rounds_clamped),
    .dn_i     (st_q == RUN),
    .cnt_o    (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      data_q <= '0;
      inv_q  <= 1'b0;
    end else begin
      unique case (st_q)
        IDLE: if (in_valid) begin
          data_q <= in_data;
          inv_q  <= in_inverse;
          st_q   <= (rounds_clamped != '0) ? RUN : DONE;
        end
        RUN: begin
          data_q <= mapped;
          if (cnt == RW'(1)) st_q <= DONE;
        end
        DONE: if (out_ready) st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state; out_data is zero outside DONE.
  assign in_ready  = (st_q == IDLE);
  assign out_valid = (st_q == DONE);
  assign busy      = (st_q == RUN) || (st_q == DONE);
  assign out_data  = (st_q == DONE) ? data_q : '0;

endmodule

// File: tb/tb_lane_permute_engine.sv
// Scoreboard bench for lane_permute_engine: a W=8 instance for the bulk of the
// scenarios and a W=1 instance for the single-bit cell-move vectors.
module tb_lane_permute_engine;
  import lane_permute_engine_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // W=8 instance
  logic         iv8 = 1'b0, ordy8 = 1'b0, iinv8 = 1'b0;
  logic [199:0] id8 = '0;
  logic [4:0]   irnd8 = '0;
  logic         ir8, ov8, busy8;
  logic [199:0] od8;

  // W=1 instance
  logic         iv1 = 1'b0, ordy1 = 1'b0, iinv1 = 1'b0;
  logic [24:0]  id1 = '0;
  logic [4:0]   irnd1 = '0;
  logic         ir1, ov1, busy1;
  logic [24:0]  od1;

  lane_permute_engine #(.W(8), .MAX_ROUNDS(24)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .in_rounds(irnd8), .in_inverse(iinv8), .out_valid(ov8), .out_ready(ordy8),
    .out_data(od8), .busy(busy8)
  );

  lane_permute_engine #(.W(1), .MAX_ROUNDS(24)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .in_rounds(irnd1), .in_inverse(iinv1), .out_valid(ov1), .out_ready(ordy1),
    .out_data(od1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  logic [199:0] exp8_q[$];
  logic [24:0]  exp1_q[$];

  function automatic logic [199:0] model(input logic [199:0] d, input int r,
                                         input logic inv, input int w);
    logic [199:0] cur, nxt;
    int rr;
    rr  = (r > 24) ? 24 : r;
    cur = d;
    for (int k = 0; k < rr; k++) begin
      nxt = '0;
      for (int i = 0; i < N_CELLS; i++)
        for (int b = 0; b < w; b++)
          if (!inv) nxt[pi_dst(i)*w + b] = cur[i*w + b];
          else      nxt[i*w + b]         = cur[pi_dst(i)*w + b];
      cur = nxt;
    end
    return cur;
  endfunction

  function automatic logic [199:0] rand200();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom()};
  endfunction

  // ---- drivers (no checking inside) ----
  task automatic start8(input logic [199:0] d, input int r, input logic inv);
    @(negedge clk);
    id8 = d; irnd8 = 5'(r); iinv8 = inv; iv8 = 1'b1;
    exp8_q.push_back(model(d, r, inv, 8));
    @(posedge clk); #1 iv8 = 1'b0;
  endtask

  task automatic wait8(output logic [199:0] d, output int lat, output bit to);
    lat = 1;
    @(negedge clk);
    while (!ov8 && lat < 60) begin @(negedge clk); lat++; end
    to = !ov8;
    d  = od8;
  endtask

  task automatic take8();
    ordy8 = 1'b1;
    @(posedge clk); #1 ordy8 = 1'b0;
  endtask

  task automatic start1(input logic [24:0] d, input int r, input logic inv,
                        input logic [24:0] expv);
    @(negedge clk);
    id1 = d; irnd1 = 5'(r); iinv1 = inv; iv1 = 1'b1;
    exp1_q.push_back(expv);
    @(posedge clk); #1 iv1 = 1'b0;
  endtask

  task automatic wait1(output logic [24:0] d, output bit to);
    int n = 1;
    @(negedge clk);
    while (!ov1 && n < 60) begin @(negedge clk); n++; end
    to = !ov1;
    d  = od1;
    ordy1 = 1'b1;
    @(posedge clk); #1 ordy1 = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ir=%b ov=%b busy=%b want ir=1 ov=0 busy=0", ir8, ov8, busy8);
    end
    checks++;
    if (od8 !== '0) begin errors++; $display("FAIL reset_data got %h want 0", od8); end
    checks++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0 || od1 !== '0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_w1 got ir=%b ov=%b od=%h busy=%b", ir1, ov1, od1, busy1);
    end
  endtask

  task automatic test_forward_basic();
    logic [24:0] vin [4] = '{25'h0000001, 25'h0000002, 25'h0001000, 25'h0000400};
    logic [24:0] vexp[4] = '{25'h0000400, 25'h0100000, 25'h0001000, 25'h0000001};
    logic        vinv[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [24:0] d, e;
    bit to;
    for (int k = 0; k < 4; k++) begin
      start1(vin[k], 1, vinv[k], vexp[k]);
      wait1(d, to);
      e = exp1_q.pop_front();
      checks++;
      if (to || d !== e) begin
        errors++;
        $display("FAIL fwd_basic_%0d got %h (timeout=%0d) want %h", k, d, to, e);
      end
    end
  endtask

  task automatic test_round_trip();
    logic [199:0] src, d, e;
    int lat; bit to;
    src = rand200();
    start8(src, 24, 1'b0);
    wait8(d, lat, to);
    e = exp8_q.pop_front();
    take8();
    checks++;
    if (to || d !== src || d !== e) begin
      errors++; $display("FAIL round_trip_24 got %h want %h", d, src);
    end
    checks++;
    if (lat != 25) begin errors++; $display("FAIL latency_24 got %0d want 25", lat); end
    // partial forward then matching inverse
    src = rand200();
    start8(src, 7, 1'b0);
    wait8(d, lat, to);
    e = exp8_q.pop_front();
    take8();
    checks++;
    if (to || d !== e) begin errors++; $display("FAIL fwd_7 got %h want %h", d, e); end
    start8(d, 7, 1'b1);
    wait8(d, lat, to);
    e = exp8_q.pop_front();
    take8();
    checks++;
    if (to || d !== src || d !== e) begin
      errors++; $display("FAIL inv_7_undo got %h want %h", d, src);
    end
  endtask

  task automatic test_zero_clamp();
    logic [199:0] src, d, e, ref24;
    int lat; bit to;
    src = rand200();
    start8(src, 0, 1'b0);
    wait8(d, lat, to);
    e = exp8_q.pop_front();
    take8();
    checks++;
    if (to || d !== src || d !== e) begin errors++; $display("FAIL zero_rounds got %h want %h", d, src); end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL latency_0 got %0d want 1", lat); end
    // clamp: 30 and 31 rounds behave as 24 (identity), 24 cycles of rounds
    src = rand200();
    ref24 = model(src, 24, 1'b1, 8);
    start8(src, 30, 1'b1);
    wait8(d, lat, to);
    e = exp8_q.pop_front();
    take8();
    checks++;
    if (to || d !== ref24 || d !== src) begin errors++; $display("FAIL clamp_30 got %h want %h", d, ref24); end
    checks++;
    if (lat != 25) begin errors++; $display("FAIL latency_clamp got %0d want 25", lat); end
    start8(src, 31, 1'b0);
    wait8(d, lat, to);
    e = exp8_q.pop_front();
    take8();
    checks++;
    if (to || d !== e) begin errors++; $display("FAIL clamp_31 got %h want %h", d, e); end
  endtask

  task automatic test_backpressure();
    logic [199:0] d, e;
    int lat; bit to;
    start8(rand200(), 3, 1'b0);
    wait8(d, lat, to);
    e = exp8_q.pop_front();
    checks++;
    if (to || d !== e) begin errors++; $display("FAIL bp_result got %h want %h", d, e); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (od8 !== e || ov8 !== 1'b1 || ir8 !== 1'b0 || busy8 !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall_%0d got od=%h ov=%b ir=%b want od=%h ov=1 ir=0", k, od8, ov8, ir8, e);
      end
    end
    take8();
    @(negedge clk);
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL bp_handoff got ir=%b ov=%b busy=%b want 1 0 0", ir8, ov8, busy8);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [199:0] d, e;
    int lat; bit to;
    start8(rand200(), 10, 1'b0);
    void'(exp8_q.pop_back());
    @(posedge clk); @(posedge clk);   // rounds 1 and 2 done
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ov8 !== 1'b0 || busy8 !== 1'b0 || ir8 !== 1'b1 || od8 !== '0) begin
      errors++;
      $display("FAIL rst_mid_run got ov=%b busy=%b ir=%b od=%h want 0 0 1 0", ov8, busy8, ir8, od8);
    end
    // reset beats a simultaneous request
    iv8 = 1'b1; id8 = rand200(); irnd8 = 5'd2; rst = 1'b1;
    @(posedge clk); #1 begin rst = 1'b0; iv8 = 1'b0; end
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++; $display("FAIL rst_vs_valid got busy=%b ir=%b want 0 1", busy8, ir8);
    end
    start8(rand200(), 5, 1'b1);
    wait8(d, lat, to);
    e = exp8_q.pop_front();
    take8();
    checks++;
    if (to || d !== e || lat != 6) begin
      errors++; $display("FAIL after_rst got %h lat %0d want %h lat 6", d, lat, e);
    end
  endtask

  task automatic test_input_hold();
    logic [199:0] d, e;
    int lat; bit to;
    start8(rand200(), 6, 1'b0);
    @(negedge clk);
    id8 = rand200(); iinv8 = 1'b1; irnd8 = 5'd1;
    @(negedge clk);
    id8 = '1;
    wait8(d, lat, to);
    e = exp8_q.pop_front();
    take8();
    checks++;
    if (to || d !== e) begin errors++; $display("FAIL input_hold got %h want %h", d, e); end
  endtask

  task automatic test_back_to_back();
    logic [199:0] d, e;
    int lat; bit to;
    for (int k = 0; k < 4; k++) begin
      start8(rand200(), int'($urandom_range(1, 24)), 1'($urandom_range(0, 1)));
      wait8(d, lat, to);
      e = exp8_q.pop_front();
      take8();
      checks++;
      if (to || d !== e) begin errors++; $display("FAIL b2b_%0d got %h want %h", k, d, e); end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_forward_basic();
    test_round_trip();
    test_zero_clamp();
    test_backpressure();
    test_reset_mid_run();
    test_input_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
